// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, taken-branch squashes and
// freezes the pipeline while a multi-cycle data access waits on the shared memory.
`default_nettype none

module hazard_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic [4:0]       ID_EX_Rd,
    input  logic             ID_EX_MemRead,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             pipe_freeze,
    output logic             mem_sel,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [0:0]       ST_RUN       = 1'b0;
    localparam logic [0:0]       ST_DATA_WAIT = 1'b1;
    localparam logic [4:0]       C_TIMEOUT    = 5'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_MAX    = {CNT_W{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [4:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_error_q, mem_error_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic dreq, lu;
    logic frozen, complete, abort;

    assign dreq = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign lu   = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                  ((ID_EX_Rd == IF_ID_rs1) || (ID_EX_Rd == IF_ID_rs2));

    // State register and performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 5'd0;
            mem_error_q <= 1'b0;
            stall_q     <= '0;
            flush_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
            stall_q     <= stall_d;
            flush_q     <= flush_d;
        end
    end

    // Next-state logic; the abort cycle is treated as a completion cycle
    always_comb begin
        frozen     = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (dreq) begin
                    if (mem_ready) begin
                        complete = 1'b1;
                    end else begin
                        frozen     = 1'b1;
                        state_d    = ST_DATA_WAIT;
                        wait_cnt_d = 5'd1;
                    end
                end
            end
            ST_DATA_WAIT: begin
                if (mem_ready) begin
                    complete = 1'b1;
                end else if (wait_cnt_q >= C_TIMEOUT) begin
                    abort    = 1'b1;
                    complete = 1'b1;
                end else begin
                    frozen     = 1'b1;
                    wait_cnt_d = wait_cnt_q + 5'd1;
                end
                if (complete) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 5'd0;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 5'd0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        mem_sel      = 1'b0;
        if (rst) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
        end else if (frozen) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_freeze = 1'b1;
            mem_sel     = 1'b1;
        end else begin
            if (complete) begin
                mem_sel     = 1'b1;
                PC_write    = 1'b0;
                IF_ID_flush = 1'b1;
            end
            if (branch_taken) begin
                PC_write     = 1'b1;
                IF_ID_write  = 1'b1;
                IF_ID_flush  = 1'b1;
                ID_EX_bubble = 1'b1;
            end else if (lu) begin
                PC_write     = 1'b0;
                IF_ID_write  = 1'b0;
                IF_ID_flush  = 1'b0;
                ID_EX_bubble = 1'b1;
            end
        end

        mem_error_d = abort;
        stall_d     = stall_q;
        flush_d     = flush_q;
        if (!PC_write && (stall_q != C_CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
        if (!frozen && branch_taken && (flush_q != C_CNT_MAX)) begin
            flush_d = flush_q + 1'b1;
        end
    end

    assign mem_error    = mem_error_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: a transaction-level model predicts each
// cycle's outputs into a queue that a negedge monitor drains and compares.
`default_nettype none

module tb_hazard_controller;

    localparam int TO = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    IF_ID_rs1 = '0, IF_ID_rs2 = '0, ID_EX_Rd = '0;
    logic          ID_EX_MemRead = 0, EX_MEM_MemRead = 0, EX_MEM_MemWrite = 0;
    logic          branch_taken = 0, mem_ready = 0;
    logic          PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble;
    logic          pipe_freeze, mem_sel, mem_error;
    logic [CW-1:0] stall_cycles, flush_count;

    hazard_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .ID_EX_Rd(ID_EX_Rd),
        .ID_EX_MemRead(ID_EX_MemRead), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_MemWrite(EX_MEM_MemWrite), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_bubble(ID_EX_bubble),
        .pipe_freeze(pipe_freeze), .mem_sel(mem_sel), .mem_error(mem_error),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]    ctrl;   // {PC_write,IF_ID_write,IF_ID_flush,bubble,freeze,mem_sel,mem_error}
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
        int            tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   tag_n = 0;

    // Transaction-level model: an outstanding access and how long it has frozen us
    bit   m_busy;
    int   m_frozen_cycles;
    bit   m_err;
    int   m_stall, m_flush;
    localparam int SAT = (1 << CW) - 1;

    task automatic model_reset();
        m_busy = 0; m_frozen_cycles = 0; m_err = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic push_reset();
        exp_t e;
        e.ctrl = 7'b0001000; e.stall = '0; e.flush = '0; e.tag = tag_n++;
        q.push_back(e);
    endtask

    task automatic rst_cycles(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        push_reset();
        for (int i = 1; i < n; i++) begin
            @(posedge clk); #1;
            push_reset();
        end
    endtask

    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input bit idmr, input bit mr, input bit mw, input bit br, input bit rdy);
        exp_t e;
        bit dreq, lu, fr, done, ab;
        bit pc, ifw, fl, bub, sel;
        @(posedge clk); #1;
        rst = 1'b0;
        IF_ID_rs1 = rs1; IF_ID_rs2 = rs2; ID_EX_Rd = rd; ID_EX_MemRead = idmr;
        EX_MEM_MemRead = mr; EX_MEM_MemWrite = mw; branch_taken = br; mem_ready = rdy;

        dreq = mr | mw;
        lu   = idmr && (rd != 0) && (rd == rs1 || rd == rs2);
        fr = 0; done = 0; ab = 0;
        if (m_busy || dreq) begin
            if (rdy) done = 1;
            else if (m_busy && m_frozen_cycles == TO) begin ab = 1; done = 1; end
            else begin fr = 1; m_busy = 1; m_frozen_cycles++; end
        end
        if (done) begin m_busy = 0; m_frozen_cycles = 0; end

        if (fr) begin
            pc = 0; ifw = 0; fl = 0; bub = 0; sel = 1;
        end else begin
            pc = !done; ifw = 1; fl = done; bub = 0; sel = done;
            if (br) begin pc = 1; ifw = 1; fl = 1; bub = 1; end
            else if (lu) begin pc = 0; ifw = 0; fl = 0; bub = 1; end
        end

        e.ctrl  = {pc, ifw, fl, bub, fr, sel, m_err};
        e.stall = CW'(m_stall);
        e.flush = CW'(m_flush);
        e.tag   = tag_n++;
        q.push_back(e);

        m_err = ab;
        if (!pc && m_stall < SAT) m_stall++;
        if (br && !fr && m_flush < SAT) m_flush++;
    endtask

    task automatic idle();
        step(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [6:0] act;
            e   = q.pop_front();
            act = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze, mem_sel, mem_error};
            total++;
            if (act !== e.ctrl) begin
                bad++;
                $display("FAIL ctrl cycle %0d: got %b want %b", e.tag, act, e.ctrl);
            end
            total++;
            if (stall_cycles !== e.stall) begin
                bad++;
                $display("FAIL stall_cycles cycle %0d: got %0d want %0d", e.tag, stall_cycles, e.stall);
            end
            total++;
            if (flush_count !== e.flush) begin
                bad++;
                $display("FAIL flush_count cycle %0d: got %0d want %0d", e.tag, flush_count, e.flush);
            end
        end
    end

    initial begin
        model_reset();
        rst_cycles(2);
        idle();

        // load-use via rs2, then recovery
        step(5'd1, 5'd5, 5'd5, 1, 0, 0, 0, 0);
        idle();
        // x0 destination and non-matching destination
        step(5'd0, 5'd9, 5'd0, 1, 0, 0, 0, 0);
        step(5'd3, 5'd4, 5'd7, 1, 0, 0, 0, 0);
        // taken branch overrides load-use
        step(5'd6, 5'd2, 5'd6, 1, 0, 0, 1, 0);
        idle();
        // zero-wait store
        step(5'd1, 5'd2, 5'd3, 0, 0, 1, 0, 1);
        idle();
        // 3-wait load, branch pulse while frozen
        step(5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0);
        step(5'd1, 5'd2, 5'd3, 0, 1, 0, 1, 0);
        step(5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0);
        step(5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 1);
        idle();
        // timeout: 16 frozen, abort, then mem_error pulse
        for (int i = 0; i < TO + 1; i++) step(5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0);
        idle();
        idle();
        // reset in the middle of a wait
        for (int i = 0; i < 3; i++) step(5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0);
        rst_cycles(2);
        idle();
        idle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst_cycles(1 + $urandom_range(0, 1));
            end else begin
                bit busy_mem;
                busy_mem = ($urandom_range(0, 3) == 0) || m_busy;
                step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)),
                     busy_mem && $urandom_range(0, 1) == 1,
                     busy_mem && $urandom_range(0, 1) == 0,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 5) < 2);
            end
        end

        @(negedge clk); #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 5-stage RISC-V core. It sits beside the forwarding logic and issues PC/IF-ID write enables, bubble and flush controls. It resolves three conditions: load-use hazards, taken-branch squashes, and structural conflicts on the single-ported unified memory. A data access can take several cycles; while it waits on `mem_ready`, the controller freezes the pipeline, with a watchdog timeout. Saturating stall and flush counters are provided for performance measurement.

## Interface
- `TIMEOUT`, 16: maximum frozen cycles per data access before abort (≥2).
- `CNT_W`, 16: width of the performance counters.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `IF_ID_rs1`, `IF_ID_rs2`  in  5 each  source registers of the instruction in ID.
- `ID_EX_Rd`  in  5  destination register of the instruction in EX.
- `ID_EX_MemRead`  in  1  instruction in EX is a load.
- `EX_MEM_MemRead`, `EX_MEM_MemWrite`  in  1 each  instruction in MEM accesses memory.
- `branch_taken`  in  1  branch in EX resolved taken this cycle.
- `mem_ready`  in  1  memory completes the current data access this cycle.
- `PC_write`  out  1  PC loads its next value.
- `IF_ID_write`  out  1  IF/ID register loads.
- `IF_ID_flush`  out  1  IF/ID loads a NOP.
- `ID_EX_bubble`  out  1  ID/EX loads a NOP (all control bits zero).
- `pipe_freeze`  out  1  ID/EX, EX/MEM and MEM/WB hold; has priority over `ID_EX_bubble`.
- `mem_sel`  out  1  0 = memory serves fetch, 1 = memory serves data.
- `mem_error`  out  1  one-cycle pulse after a timed-out access.
- `stall_cycles`  out  CNT_W  count of cycles with `PC_write`=0.
- `flush_count`  out  CNT_W  count of taken-branch flushes.

## Operation
- State register with two states: RUN and DATA_WAIT. The 5-bit wait counter is `wait_cnt`.
- **Data request (`dreq`):** `EX_MEM_MemRead` | `EX_MEM_MemWrite`.
- **Load-use hazard (`lu`):** `ID_EX_MemRead` && `ID_EX_Rd`≠0 && (`ID_EX_Rd`==`IF_ID_rs1` || `ID_EX_Rd`==`IF_ID_rs2`).
- **Default outputs:** `PC_write`=1, `IF_ID_write`=1, all other outputs 0.
- **RUN, `dreq` with `mem_ready`=0:**
  - Drive `mem_sel`=1, `pipe_freeze`=1, `PC_write`=0, `IF_ID_write`=0.
  - Ignore `branch_taken` and `lu`.
  - Next state DATA_WAIT; `wait_cnt` is set to 1.
- **Completion cycle:** RUN with `dreq` and `mem_ready`=1, or DATA_WAIT with `mem_ready`=1, or the abort cycle.
  - Drive `mem_sel`=1, `pipe_freeze`=0.
  - The fetch is lost: `PC_write`=0 and `IF_ID_flush`=1.
  - Then apply `branch_taken` and `lu` as below.
  - Next state RUN.
- **DATA_WAIT, `mem_ready`=0, `wait_cnt`<`TIMEOUT`:**
  - Same outputs as the entry cycle (frozen, `mem_sel`=1).
  - `wait_cnt`++.
- **DATA_WAIT, `mem_ready`=0, `wait_cnt`==`TIMEOUT`:** abort.
  - This cycle behaves as a completion cycle.
  - `mem_error`=1 on the following cycle.
- **`branch_taken` (when not frozen):**
  - `PC_write`=1 (target load), `IF_ID_flush`=1, `ID_EX_bubble`=1, `IF_ID_write`=1.
  - Overrides `lu`; `flush_count`++.
- **`lu` without `branch_taken` (when not frozen):**
  - `PC_write`=0, `IF_ID_write`=0, `ID_EX_bubble`=1.
  - `IF_ID_flush` is forced to 0, because the held IF/ID instruction is valid.
- Counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- **Reset, asynchronous:**
  - State RUN, `wait_cnt`=0, `mem_error`=0, `stall_cycles`=0, `flush_count`=0.
  - While `rst`=1: `PC_write`=0, `IF_ID_write`=0, `ID_EX_bubble`=1; `IF_ID_flush`, `pipe_freeze`, `mem_sel` are 0.
- **Reset mid-access:** returns immediately to RUN; no `mem_error` is issued.
- **Latency:** all pipeline controls are combinational from current state and inputs, so they are valid in the same cycle.
- **Registered outputs:** `mem_error` and the counters update on the rising edge and are visible one cycle later.
- **Load-use:** costs exactly 1 stall cycle. It is not re-asserted next cycle, because the load has then moved to MEM.
- **Data access, zero wait:** 1 lost fetch cycle.
- **Data access with N wait cycles:** N frozen cycles plus 1 completion cycle.
- **Worst case:** `TIMEOUT` frozen cycles.

## Test plan
- **Load-use:** `ID_EX_MemRead`=1, `ID_EX_Rd`=5, `IF_ID_rs2`=5, no `dreq` → `PC_write`=0, `IF_ID_write`=0, `ID_EX_bubble`=1 for 1 cycle; `stall_cycles` 0→1.
- **x0 and non-matching destination:** `ID_EX_Rd`=0 with `IF_ID_rs1`=0, then `ID_EX_Rd`=7 with rs1=3, rs2=4 → no stall in either case.
- **Taken branch with load-use:** `branch_taken`=1 and `lu`=1 in the same cycle → `PC_write`=1, `IF_ID_flush`=1, `ID_EX_bubble`=1; `flush_count`=1.
- **Zero-wait store:** `EX_MEM_MemWrite`=1, `mem_ready`=1 → `mem_sel`=1, `PC_write`=0, `IF_ID_flush`=1, `pipe_freeze`=0; state stays RUN.
- **3-wait load:** `mem_ready` rises on cycle 4 → `pipe_freeze`=1 for cycles 1–3, completion on cycle 4, RUN on cycle 5. A `branch_taken` pulse on cycle 2 has no effect.
- **Timeout:** `mem_ready` held 0 with `TIMEOUT`=16 → 16 frozen cycles, abort on cycle 17, `mem_error` pulse on cycle 18.
- **Reset mid-access:** `rst` asserted during DATA_WAIT → state RUN and counters 0 immediately, no `mem_error`.
